// File: rtl/multi_phase_light_controller.sv
// Round-robin N-approach signal controller with walk phase, green extension, demand skipping, reprogrammable durations.
// Latency: lamps are a Moore decode of registered state and change on the transition edge; backpressure: none, all timing is gated by tick.
module multi_phase_light_controller #(
    parameter int N_PHASES   = 2,
    parameter int TIME_WIDTH = 4,
    parameter int DEF_GREEN  = 5,
    parameter int DEF_EXT    = 3,
    parameter int DEF_YELLOW = 2,
    parameter int DEF_ALLRED = 1,
    parameter int MAX_EXT    = 2,
    parameter int SKIP_EMPTY = 0,
    localparam int PW        = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [N_PHASES-1:0]   trafficSensor,
    input  logic                  walkRequest,
    input  logic                  reprogram,
    input  logic [1:0]            timeSelector,
    input  logic [TIME_WIDTH-1:0] timeValue,
    output logic [N_PHASES-1:0]   red,
    output logic [N_PHASES-1:0]   yellow,
    output logic [N_PHASES-1:0]   green,
    output logic                  walkLight,
    output logic [PW-1:0]         activePhase,
    output logic                  walkPending
);

    localparam int EXT_W = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        WALK   = 2'd3
    } state_t;

    state_t                  state, stateNext;
    logic [PW-1:0]           phaseNext;
    logic [TIME_WIDTH-1:0]   counter, counterNext;
    logic [EXT_W-1:0]        extCount, extNext;
    logic [TIME_WIDTH-1:0]   greenDur, extDur, yellowDur, allredDur;
    logic [N_PHASES-1:0]     demand;
    logic                    reprogramDly;
    logic                    greenEntry, walkEntry, expire;
    logic [PW-1:0]           rotPhase;
    logic                    found;
    int                      idx;

    // Candidate for the next green: plain rotation, or first approach with demand
    // scanning forward from the one just served (wrapping back to it last).
    always_comb begin
        rotPhase = (activePhase == PW'(N_PHASES - 1)) ? '0 : activePhase + PW'(1);
        found    = 1'b0;
        idx      = 0;
        if (SKIP_EMPTY != 0) begin
            for (int off = 1; off <= N_PHASES; off++) begin
                idx = (int'(activePhase) + off) % N_PHASES;
                if (!found && demand[idx[PW-1:0]]) begin
                    found    = 1'b1;
                    rotPhase = idx[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        stateNext   = state;
        phaseNext   = activePhase;
        counterNext = tick ? counter - TIME_WIDTH'(1) : counter;
        extNext     = extCount;
        greenEntry  = 1'b0;
        walkEntry   = 1'b0;
        expire      = tick && (counter == TIME_WIDTH'(1));
        if (expire) begin
            case (state)
                GREEN: begin
                    if (trafficSensor[activePhase] && (extCount < EXT_W'(MAX_EXT))) begin
                        counterNext = extDur;
                        extNext     = extCount + EXT_W'(1);
                    end else begin
                        stateNext   = YELLOW;
                        counterNext = yellowDur;
                    end
                end
                YELLOW: begin
                    stateNext   = ALLRED;
                    counterNext = allredDur;
                end
                ALLRED: begin
                    if (walkPending) begin
                        stateNext   = WALK;
                        counterNext = greenDur;
                        walkEntry   = 1'b1;
                    end else begin
                        stateNext   = GREEN;
                        phaseNext   = rotPhase;
                        counterNext = greenDur;
                        extNext     = '0;
                        greenEntry  = 1'b1;
                    end
                end
                WALK: begin
                    stateNext   = GREEN;
                    phaseNext   = rotPhase;
                    counterNext = greenDur;
                    extNext     = '0;
                    greenEntry  = 1'b1;
                end
                default: stateNext = GREEN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= GREEN;
            activePhase <= '0;
            counter     <= TIME_WIDTH'(DEF_GREEN);
            extCount    <= '0;
            walkPending <= 1'b0;
            demand      <= '0;
        end else begin
            state       <= stateNext;
            activePhase <= phaseNext;
            counter     <= counterNext;
            extCount    <= extNext;
            if (walkEntry)
                walkPending <= 1'b0;
            else if (walkRequest)
                walkPending <= 1'b1;
            // Serving approach k clears its demand even if its sensor is still high.
            for (int k = 0; k < N_PHASES; k++) begin
                if (greenEntry && (phaseNext == PW'(k)))
                    demand[k] <= 1'b0;
                else if (trafficSensor[k] && !((state == GREEN) && (activePhase == PW'(k))))
                    demand[k] <= 1'b1;
            end
        end
    end

    // Duration registers are written only on a rising reprogram strobe; loads on
    // the same edge still see the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reprogramDly <= 1'b0;
            greenDur     <= TIME_WIDTH'(DEF_GREEN);
            extDur       <= TIME_WIDTH'(DEF_EXT);
            yellowDur    <= TIME_WIDTH'(DEF_YELLOW);
            allredDur    <= TIME_WIDTH'(DEF_ALLRED);
        end else begin
            reprogramDly <= reprogram;
            if (reprogram && !reprogramDly && (timeValue != '0)) begin
                case (timeSelector)
                    2'b00:   greenDur  <= timeValue;
                    2'b01:   extDur    <= timeValue;
                    2'b10:   yellowDur <= timeValue;
                    default: allredDur <= timeValue;
                endcase
            end
        end
    end

    always_comb begin
        red       = '1;
        yellow    = '0;
        green     = '0;
        walkLight = (state == WALK);
        case (state)
            GREEN: begin
                green[activePhase] = 1'b1;
                red[activePhase]   = 1'b0;
            end
            YELLOW: begin
                yellow[activePhase] = 1'b1;
                red[activePhase]    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multi_phase_light_controller.md
# multi_phase_light_controller

Parametrised intersection controller serving `N_PHASES` vehicle approaches round-robin, with a pedestrian walk phase, sensor-driven green extension, optional skipping of approaches with no demand, and run-time reprogrammable interval durations. It is the next-generation replacement for the fixed two-road traffic controller. It sits behind the input synchroniser/debounce and clock-divider stages, and consumes a one-cycle `tick` enable for all timing.

## Interface
- `N_PHASES`, 2: number of vehicle approaches; must be ≥2.
- `TIME_WIDTH`, 4: width of every duration register and of the interval counter.
- `DEF_GREEN`, 5: reset value of the base-green duration, in ticks. This duration is also used for walk.
- `DEF_EXT`, 3: reset value of the extension duration, in ticks.
- `DEF_YELLOW`, 2: reset value of the yellow duration, in ticks.
- `DEF_ALLRED`, 1: reset value of the all-red clearance duration, in ticks.
- `MAX_EXT`, 2: maximum number of extensions granted per green.
- `SKIP_EMPTY`, 0: 1 = skip approaches with no latched demand.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  timing enable; one tick = one count of the interval counter.
- `trafficSensor`  in  N_PHASES  per-approach vehicle presence, synchronous level.
- `walkRequest`  in  1  pedestrian request, synchronous level.
- `reprogram`  in  1  write strobe for a duration register.
- `timeSelector`  in  2  selects the register to write: 00 green, 01 ext, 10 yellow, 11 allred.
- `timeValue`  in  TIME_WIDTH  value to write.
- `red`, `yellow`, `green`  out  N_PHASES  per-approach lamps.
- `walkLight`  out  1  pedestrian walk lamp.
- `activePhase`  out  max(1,clog2(N_PHASES))  index of the approach being served.
- `walkPending`  out  1  latched walk request not yet served.

## Operation
- States: GREEN, YELLOW, ALLRED, WALK.
- Lamp outputs are a Moore decode of registered state and `activePhase`:
  - GREEN/YELLOW: only `activePhase` is green/yellow; all other approaches are red.
  - ALLRED/WALK: all approaches red.
  - `walkLight` is 1 only in WALK.
- Interval counter:
  - Loaded with the state's duration on the entry edge.
  - Decrements on each cycle with `tick`=1.
  - When it is 1 and `tick`=1, the state transitions on that edge. A duration of D therefore lasts exactly D ticks.
- Extension:
  - GREEN expiry with `trafficSensor[activePhase]`=1 and `extCount`<`MAX_EXT` reloads the counter with the ext duration and increments `extCount`.
  - Otherwise GREEN expiry goes to YELLOW.
  - `extCount` clears on GREEN entry.
- Transitions:
  - YELLOW → ALLRED.
  - ALLRED → WALK if `walkPending`=1. `walkPending` clears on WALK entry.
  - Otherwise ALLRED → GREEN of the next phase. WALK also → GREEN of the next phase.
- Next phase:
  - `SKIP_EMPTY`=0: (`activePhase`+1) mod `N_PHASES`.
  - `SKIP_EMPTY`=1: the first index after `activePhase`, cyclically, with `demand`=1. If no approach has demand, use (`activePhase`+1) mod `N_PHASES`.
- Demand latch:
  - `demand[k]` is set while `trafficSensor[k]`=1, except when approach k is in GREEN.
  - `demand[k]` clears on GREEN entry for k; the clear wins over a set on the same edge.
- Walk latch:
  - `walkRequest`=1 sets `walkPending`.
  - A request during WALK re-latches for the next cycle.
- Reprogram:
  - Rising edge of `reprogram` (edge-detected internally) writes `timeValue` into the selected register.
  - `timeValue`=0 is rejected and the register is unchanged.
  - The interval in progress is unaffected; the new value applies from the next load.
- Width: counter and registers are `TIME_WIDTH` bits, so the maximum duration is 2^TIME_WIDTH−1. There is no wrap, because loads are always ≥1.

## Timing
- Reset (asynchronous, immediate) sets:
  - state GREEN, `activePhase`=0, counter=`DEF_GREEN`.
  - all duration registers to their defaults.
  - `demand`, `walkPending` and `extCount` cleared.
  - outputs: `green[0]`=1, `red[N-1:1]`=all 1, every other lamp 0, `walkLight`=0.
- Lamp change latency: outputs change on the same edge as the state transition; no extra pipeline stage.
- Reprogram on the same edge as a load of that register: the load uses the old value; the write is visible one cycle later.
- `tick` held high counts once per clock cycle.
- Reset asserted mid-interval aborts the interval and any extension or walk in progress. Pending requests are lost.

## Test plan
- Defaults, `N_PHASES`=2, no inputs, reset, then 16 ticks → phase0 green 5 ticks, yellow 2, allred 1; phase1 green 5, yellow 2, allred 1; back to phase0 green.
- Hold `trafficSensor[0]`=1 through phase0 green → green lasts 5+3+3=11 ticks (`MAX_EXT`=2), then yellow.
- Pulse `walkRequest` during phase1 green → `walkPending`=1; after phase1 allred, WALK for 5 ticks with all red and `walkLight`=1; then phase0 green and `walkPending`=0.
- Reprogram sel=00 val=3 mid-green → current green completes at the old length; next green lasts 3 ticks. Then sel=10 val=0 → yellow stays 2 ticks.
- `N_PHASES`=4, `SKIP_EMPTY`=1, only `trafficSensor[2]` pulsed during phase0 green → after phase0 allred, `activePhase`=2. With no demand afterwards, 3 follows 2.
- Assert `reset` during phase1 yellow with `walkPending`=1 → outputs return immediately to phase0 green; `walkPending`=0; the next green lasts 5 ticks.
